// File: rtl/rbe_binconv_accumulator.sv
// Binary-convolution popcount accumulator: weights each popcount beat by 2^(i+j) and sums a job into one result.
// Optional build macro RBE_BINCONV_ACC_SATURATE_EN makes every addition saturate instead of wrapping.
module rbe_binconv_accumulator #(
  parameter int unsigned TP    = 32,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned PW   = $clog2(TP) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [3:0]       qa_i,
  input  logic [3:0]       qw_i,
  input  logic [CNT_W-1:0] n_i,
  input  logic             pop_valid_i,
  output logic             pop_ready_o,
  input  logic [PW-1:0]    pop_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o
);

  // Wide enough to hold the accumulator plus the largest shifted beat and a carry.
  localparam int unsigned SUM_W = ((ACC_W > PW + 14) ? ACC_W : PW + 14) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [2:0]       i_q, j_q;
  logic [CNT_W-1:0] k_q;
  logic [2:0]       qa_last_q, qw_last_q;
  logic [CNT_W-1:0] n_last_q;
  logic             done_q;
  logic [3:0]       shift;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PW-1:0]    p,
                                               input logic [3:0]       sh);
`ifdef RBE_BINCONV_ACC_SATURATE_EN
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + (SUM_W'(p) << sh);
    if (|sum[SUM_W-1:ACC_W]) return '1;
    return sum[ACC_W-1:0];
`else
    return a + ACC_W'(SUM_W'(p) << sh);
`endif
  endfunction

  assign shift = {1'b0, i_q} + {1'b0, j_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      qa_last_q <= '0;
      qw_last_q <= '0;
      n_last_q  <= '0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      qa_last_q <= '0;
      qw_last_q <= '0;
      n_last_q  <= '0;
      done_q    <= 1'b0;
    end else if (enable_i) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // Terminal counts are stored as value-1, with 0 coerced to 1.
            qa_last_q <= (qa_i == 4'd0) ? 3'd0 : 3'(qa_i - 4'd1);
            qw_last_q <= (qw_i == 4'd0) ? 3'd0 : 3'(qw_i - 4'd1);
            n_last_q  <= (n_i == '0) ? '0 : n_i - CNT_W'(1);
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (pop_valid_i) begin
            acc_q <= acc_add(acc_q, pop_data_i, shift);
            if (j_q == qw_last_q) begin
              j_q <= '0;
              if (i_q == qa_last_q) begin
                i_q <= '0;
                if (k_q == n_last_q) begin
                  k_q     <= '0;
                  state_q <= S_OUTPUT;
                end else begin
                  k_q <= k_q + CNT_W'(1);
                end
              end else begin
                i_q <= i_q + 3'd1;
              end
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        S_OUTPUT: begin
          if (out_ready_i) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end else begin
      done_q <= 1'b0;
    end
  end

  assign pop_ready_o = (state_q == S_ACCUM) & enable_i;
  assign out_valid_o = (state_q == S_OUTPUT);
  assign out_data_o  = out_valid_o ? acc_q : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule
